ram_512x16: RTL and testbench
=============================

Name: ram_512x16

Overview:
- 512-word × 16-bit register-file RAM, nand2tetris-style building block of the memory subsystem.
- Reads are combinational from the addressed word. Writes are synchronous on the rising clock edge when load is high.
- Reset is asynchronous and clears every word.
- Built hierarchically: 8 banks of 64 words, each 64-word bank being 8 banks of 8 words, each 8-word bank being 8 16-bit registers. A flat equivalent is acceptable if behaviour is identical.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 9, address width; depth = 2**ADDR_WIDTH = 512.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high; clears all 512 words to 0.
- in  input  16  write data.
- address  input  9  word select for both read and write.
- load  input  1  write enable, sampled at rising clk.
- out  output  16  contents of word[address].

Behaviour:
- Storage: mem[0..511], 16 bits each, no uninitialised state after first reset.
- Reset:
  - reset=1 forces every word to 16'h0000 immediately, without waiting for clk.
  - out=0 while reset is high.
  - Reset dominates load. A write on an edge where reset=1 is discarded.
  - Deassertion is synchronised by the user. Words stay 0 until written.
- Write:
  - On posedge clk with reset=0 and load=1: mem[address] <= in.
  - Exactly one word changes. All others hold.
  - load=0 means no storage changes, regardless of in/address.
- Read:
  - out = mem[address], combinational, zero-cycle latency.
  - An address change updates out within the same delta/cycle, no clock needed.
- Read-during-write, same address:
  - Before the edge, out shows the old value.
  - After the edge, out shows the newly written value in the same cycle the edge occurs. No write-through bypass of in before the edge.
- Address decode:
  - address[8:6] selects the 64-word bank.
  - address[5:3] selects the 8-word sub-bank.
  - address[2:0] selects the register.
  - Full 9-bit decode, no aliasing, no wrap. All 512 addresses are valid.
- Boundary addresses: 0 and 511 behave identically to interior addresses.
- Back-to-back writes to different addresses on consecutive edges each land independently.
- No X propagation: with a known address after reset, out is always a known value.

Test Plan:
- Reset: assert reset=1 asynchronously mid-cycle → out=0 immediately. Read addresses 0, 0x075, 0x1FF after deassert → all 0.
- Write/read at address 0:
  - in=0x0001, load=1, address=9'b000000000, one rising edge → out=0x0001.
  - Then load=0, in=0x0003 for several edges → address 0 still reads 0x0001.
- Non-write isolation: load=0 with in=0x0007/0x000F/0x001F/0x0077 at addresses 0x066, 0x1C0, 0x143, 0x1F7 → out=0 at each (unwritten). Address 0 remains 0x0001.
- Distinct writes:
  - load=1, address=0x002, in=0x1F01, edge → out=0x1F01.
  - Then load=1, address=0x027, in=0xFFFF, edge → out=0xFFFF.
  - Re-read 0x002 → 0x1F01. Re-read 0x000 → 0x0001.
- Decode coverage: write (address ^ 0xA5A5) & 0xFFFF to every address 0..511, then read all back → each matches, proving no aliasing across bank/sub-bank/register fields.
- Reset over data and reset-vs-load: after the writes above, pulse reset with load=1 held across a clock edge → all words 0, including 0x000, 0x002, 0x027, 0x1FF. The in value is not stored.
- Clock for all scenarios: 50% duty, period 10 time units, stimulus changing on non-edge times.

Source files
------------

// File: rtl/ram_512x16.sv
// 512x16 register-file RAM: 8 banks of 64, each 8 banks of 8 registers.
// Combinational read, synchronous write, asynchronous clear.

module ram512_reg16 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= in;
      end
   end

   assign out = r_q;

endmodule

module ram512_bank8 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic [2:0]            address,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] w_q  [8];
   logic [7:0]            w_ld;

   always_comb begin
      w_ld = '0;
      w_ld[address] = load;
   end

   for (genvar g = 0; g < 8; g++) begin : g_reg
      ram512_reg16 #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_reg (
         .clk  (clk),
         .reset(reset),
         .in   (in),
         .load (w_ld[g]),
         .out  (w_q[g])
      );
   end

   assign out = w_q[address];

endmodule

module ram512_bank64 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic [5:0]            address,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] w_q  [8];
   logic [7:0]            w_ld;

   always_comb begin
      w_ld = '0;
      w_ld[address[5:3]] = load;
   end

   for (genvar g = 0; g < 8; g++) begin : g_sub
      ram512_bank8 #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_sub (
         .clk    (clk),
         .reset  (reset),
         .in     (in),
         .address(address[2:0]),
         .load   (w_ld[g]),
         .out    (w_q[g])
      );
   end

   assign out = w_q[address[5:3]];

endmodule

module ram_512x16 #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] w_q  [8];
   logic [7:0]            w_ld;

   // Top three address bits pick the 64-word bank
   always_comb begin
      w_ld = '0;
      w_ld[address[8:6]] = load;
   end

   for (genvar g = 0; g < 8; g++) begin : g_bank
      ram512_bank64 #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_bank (
         .clk    (clk),
         .reset  (reset),
         .in     (in),
         .address(address[5:0]),
         .load   (w_ld[g]),
         .out    (w_q[g])
      );
   end

   assign out = w_q[address[8:6]];

endmodule

// File: tb/tb_ram_512x16.sv
// Directed self-checking bench for ram_512x16.
// Covers reset, write/read, isolation, full decode sweep and reset-vs-load.

module tb_ram_512x16;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic [8:0]  address;
   logic        load;
   logic [15:0] out;

   int n_tests = 0;
   int n_fail  = 0;

   ram_512x16 dut (
      .clk    (clk),
      .reset  (reset),
      .in     (in),
      .address(address),
      .load   (load),
      .out    (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] exp);
      n_tests++;
      assert (out === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, out, exp);
      end
   endtask

   task automatic wr(input logic [8:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a;
      in      = d;
      load    = 1'b1;
      @(posedge clk);
      #1;
      load    = 1'b0;
   endtask

   task automatic rd(input logic [8:0] a, input string tag,
                     input logic [15:0] exp);
      address = a;
      #1;
      chk(tag, exp);
   endtask

   logic [15:0] pat;

   initial begin
      reset   = 1'b0;
      load    = 1'b0;
      in      = 16'h0000;
      address = 9'h000;

      // Asynchronous reset asserted mid-cycle
      #3;
      reset = 1'b1;
      #1;
      chk("reset_async", 16'h0000);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rd(9'h000, "reset_a000", 16'h0000);
      rd(9'h075, "reset_a075", 16'h0000);
      rd(9'h1FF, "reset_a1ff", 16'h0000);

      // Write/read at address 0
      wr(9'h000, 16'h0001);
      chk("wr_a000", 16'h0001);

      @(negedge clk);
      in   = 16'h0003;
      load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_a000", 16'h0001);

      // load=0 never stores
      @(negedge clk);
      address = 9'h066; in = 16'h0007;
      @(posedge clk); #1;
      chk("iso_a066", 16'h0000);
      @(negedge clk);
      address = 9'h1C0; in = 16'h000F;
      @(posedge clk); #1;
      chk("iso_a1c0", 16'h0000);
      @(negedge clk);
      address = 9'h143; in = 16'h001F;
      @(posedge clk); #1;
      chk("iso_a143", 16'h0000);
      @(negedge clk);
      address = 9'h1F7; in = 16'h0077;
      @(posedge clk); #1;
      chk("iso_a1f7", 16'h0000);
      rd(9'h000, "iso_a000", 16'h0001);

      // Distinct writes
      wr(9'h002, 16'h1F01);
      chk("wr_a002", 16'h1F01);
      wr(9'h027, 16'hFFFF);
      chk("wr_a027", 16'hFFFF);
      rd(9'h002, "rerd_a002", 16'h1F01);
      rd(9'h000, "rerd_a000", 16'h0001);

      // Read during write: old value before edge, new after
      @(negedge clk);
      address = 9'h100;
      in      = 16'h1234;
      load    = 1'b1;
      #1;
      chk("rdw_before", 16'h0000);
      @(posedge clk);
      #1;
      chk("rdw_after", 16'h1234);
      load = 1'b0;

      // Back-to-back writes across every address
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         address = 9'(i);
         in      = 16'(i ^ 16'hA5A5);
         load    = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 512; i++) begin
         pat = 16'(i ^ 16'hA5A5);
         rd(9'(i), $sformatf("sweep_a%03h", i), pat);
      end

      // Reset over data with load held across an edge
      @(negedge clk);
      address = 9'h002;
      in      = 16'hBEEF;
      load    = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_data", 16'h0000);
      @(posedge clk);
      #1;
      chk("rst_vs_load", 16'h0000);
      @(negedge clk);
      load  = 1'b0;
      reset = 1'b0;
      rd(9'h000, "rst_a000", 16'h0000);
      rd(9'h002, "rst_a002", 16'h0000);
      rd(9'h027, "rst_a027", 16'h0000);
      rd(9'h1FF, "rst_a1ff", 16'h0000);
      rd(9'h100, "rst_a100", 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
